// File: rtl/pe_node.sv
// Processing-element node: a command-driven flit generator feeding per-port output FIFOs,
// plus a round-robin receive arbiter. Define PE_NODE_RX_STICKY_EN to make control_out hold its last value.
module pe_node #(
    parameter int WIDTH  = 32,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NPORTS*WIDTH-1:0]  inport_dataIn,
    input  logic [NPORTS-1:0]        inport_dataValid,
    output logic [NPORTS-1:0]        inport_dataDeq,
    output logic [NPORTS*WIDTH-1:0]  outport_dataOut,
    output logic [NPORTS-1:0]        outport_dataValid,
    input  logic [NPORTS-1:0]        outport_dataDeq,
    input  logic [WIDTH-1:0]         control_in,
    output logic [WIDTH-1:0]         control_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = WIDTH - 16;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic           w_cmd_start;
    logic [7:0]     w_cmd_len;
    logic [3:0]     w_cmd_port;
    logic [SW-1:0]  w_cmd_seed;
    logic           w_cmd_port_ok;

    assign w_cmd_start   = control_in[0];
    assign w_cmd_len     = control_in[8:1];
    assign w_cmd_port    = control_in[12:9];
    assign w_cmd_seed    = control_in[WIDTH-1:16];
    assign w_cmd_port_ok = ({1'b0, w_cmd_port} < 5'(NPORTS));

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_len;
    logic [7:0]     r_cnt;
    logic [3:0]     r_port;
    logic [SW-1:0]  r_seed;
    logic           w_accept;
    logic           w_enq;
    logic           w_port_full;
    logic [NPORTS-1:0] w_full;
    logic [WIDTH-1:0]  w_flit;

    assign w_flit = WIDTH'(r_seed) + WIDTH'(r_cnt);

    always_comb begin
        w_port_full = 1'b1;
        for (int p = 0; p < NPORTS; p++) begin
            if (r_port == 4'(p)) w_port_full = w_full[p];
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_enq       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_start) begin
                    if (!w_cmd_port_ok) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (w_cmd_len != 8'd0) ? S_SEND : S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (!w_port_full) begin
                    w_enq = 1'b1;
                    if (r_cnt == r_len - 8'd1) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_cmd_start) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_port <= '0;
            r_seed <= '0;
        end else if (w_accept) begin
            r_len  <= w_cmd_len;
            r_cnt  <= '0;
            r_port <= w_cmd_port;
            r_seed <= w_cmd_seed;
        end else if (w_enq) begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFOs, one per port
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPORTS; p++) begin : g_fifo
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wptr;
        logic [AW-1:0]    r_rptr;
        logic [CW-1:0]    r_count;
        logic             r_full;
        logic             w_push;
        logic             w_pop;
        logic [CW-1:0]    w_count_nxt;

        // Push is already gated by the registered full flag inside the FSM.
        assign w_push = w_enq && (r_port == 4'(p));
        assign w_pop  = outport_dataDeq[p] && (r_count != '0);

        always_comb begin
            w_count_nxt = r_count;
            if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
            else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == CW'(DEPTH));
            end
        end

        // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
        always_ff @(posedge CLK) begin
            if (w_push) r_mem[r_wptr] <= w_flit;
        end

        assign w_full[p]                            = r_full;
        assign outport_dataOut[p*WIDTH +: WIDTH]    = r_mem[r_rptr];
        assign outport_dataValid[p]                 = (r_count != '0);
    end

    // ------------------------------------------------------------------
    // Receive arbiter
    // ------------------------------------------------------------------
    logic [3:0]        r_rr;
    logic              w_grant_any;
    logic [3:0]        w_grant_idx;
    logic [WIDTH-1:0]  w_grant_data;
    logic [NPORTS-1:0] w_grant_onehot;
    int                w_best;
    logic [WIDTH-1:0]  r_ctrl_out;

    // Pick the valid port with the smallest rotational distance from the pointer.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_idx  = '0;
        w_grant_data = '0;
        w_best       = NPORTS;
        for (int p = 0; p < NPORTS; p++) begin
            if (inport_dataValid[p] && (((p + NPORTS - int'(r_rr)) % NPORTS) < w_best)) begin
                w_best       = (p + NPORTS - int'(r_rr)) % NPORTS;
                w_grant_any  = 1'b1;
                w_grant_idx  = 4'(p);
                w_grant_data = inport_dataIn[p*WIDTH +: WIDTH];
            end
        end
        for (int p = 0; p < NPORTS; p++) begin
            w_grant_onehot[p] = w_grant_any && (w_grant_idx == 4'(p));
        end
    end

    assign inport_dataDeq = RST ? '0 : w_grant_onehot;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr <= '0;
        end else if (w_grant_any) begin
            r_rr <= (w_grant_idx == 4'(NPORTS - 1)) ? 4'd0 : w_grant_idx + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl_out <= '0;
        end else if (w_grant_any) begin
            r_ctrl_out <= {1'b1, w_grant_idx, w_grant_data[WIDTH-6:0]};
        end
`ifdef PE_NODE_RX_STICKY_EN
        else begin
            r_ctrl_out <= r_ctrl_out;
        end
`else
        else begin
            r_ctrl_out <= '0;
        end
`endif
    end

    assign control_out = r_ctrl_out;

    // Reserved command bits and the flit bits displaced by the status header are intentionally dropped.
    logic w_unused_bits;
    assign w_unused_bits = ^{control_in[15:13], w_grant_data[WIDTH-1:WIDTH-5]};

endmodule

// File: tb/tb_pe_node.sv
// Directed self-checking bench for pe_node: reset, send path, FIFO stall, arbiter, sticky status, mid-send reset.
module tb_pe_node;

    localparam int WIDTH  = 32;
    localparam int NPORTS = 2;
    localparam int DEPTH  = 4;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NPORTS*WIDTH-1:0] inport_dataIn;
    logic [NPORTS-1:0]       inport_dataValid;
    logic [NPORTS-1:0]       inport_dataDeq;
    logic [NPORTS*WIDTH-1:0] outport_dataOut;
    logic [NPORTS-1:0]       outport_dataValid;
    logic [NPORTS-1:0]       outport_dataDeq;
    logic [WIDTH-1:0]        control_in;
    logic [WIDTH-1:0]        control_out;

    int checks   = 0;
    int failures = 0;

    pe_node #(.WIDTH(WIDTH), .NPORTS(NPORTS), .DEPTH(DEPTH)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .inport_dataIn     (inport_dataIn),
        .inport_dataValid  (inport_dataValid),
        .inport_dataDeq    (inport_dataDeq),
        .outport_dataOut   (outport_dataOut),
        .outport_dataValid (outport_dataValid),
        .outport_dataDeq   (outport_dataDeq),
        .control_in        (control_in),
        .control_out       (control_out)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [WIDTH-1:0] port_data(input int p);
        logic [NPORTS*WIDTH-1:0] v;
        v = outport_dataOut;
        return v[p*WIDTH +: WIDTH];
    endfunction

    task automatic test_reset();
        RST              = 1'b1;
        inport_dataIn    = {32'h0000_000B, 32'h0000_000A};
        inport_dataValid = 2'b11;
        outport_dataDeq  = 2'b00;
        control_in       = 32'h0010_0207;
        #3;
        checks++; if (inport_dataDeq !== 2'b00) begin failures++; $display("FAIL reset_deq: got %b want 00", inport_dataDeq); end
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b want 00", outport_dataValid); end
        checks++; if (control_out !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", control_out); end
        step(2);
        checks++; if (outport_dataValid !== 2'b00 || control_out !== 32'h0) begin failures++; $display("FAIL reset_held: got valid=%b ctrl=%h want 00/0", outport_dataValid, control_out); end
        control_in       = 32'h0;
        inport_dataValid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
        step(1);
        checks++; if (outport_dataValid !== 2'b00 || control_out !== 32'h0) begin failures++; $display("FAIL reset_release: got valid=%b ctrl=%h want 00/0", outport_dataValid, control_out); end
    endtask

    task automatic test_send_basic();
        outport_dataDeq = 2'b10;
        control_in      = 32'h0010_0207;   // SEED=0x10 PORT=1 LEN=3 START
        step(1);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL send_latch_valid: got %b want 00", outport_dataValid); end
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (outport_dataValid !== 2'b10 || port_data(1) !== 32'h10 + 32'(i)) begin
                failures++; $display("FAIL send_flit%0d: got valid=%b data=%h want 10/%h", i, outport_dataValid, port_data(1), 32'h10 + 32'(i));
            end
        end
        step(1);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL send_drained: got %b want 00", outport_dataValid); end
        step(2);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL send_done_no_repeat: got %b want 00", outport_dataValid); end
        control_in      = 32'h0;
        outport_dataDeq = 2'b00;
        step(2);
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] tail [3] = '{32'h23, 32'h24, 32'h25};
        control_in = 32'h0020_000D;        // SEED=0x20 PORT=0 LEN=6 START
        step(5);
        checks++; if (outport_dataValid !== 2'b01 || port_data(0) !== 32'h20) begin failures++; $display("FAIL stall_fill: got valid=%b head=%h want 01/20", outport_dataValid, port_data(0)); end
        step(3);
        checks++; if (port_data(0) !== 32'h20) begin failures++; $display("FAIL stall_hold: got head=%h want 20", port_data(0)); end
        outport_dataDeq = 2'b01; step(1);
        checks++; if (port_data(0) !== 32'h21) begin failures++; $display("FAIL stall_pop1: got head=%h want 21", port_data(0)); end
        outport_dataDeq = 2'b00; step(1);
        outport_dataDeq = 2'b01; step(1);
        checks++; if (port_data(0) !== 32'h22) begin failures++; $display("FAIL stall_pop2: got head=%h want 22", port_data(0)); end
        outport_dataDeq = 2'b00; step(1);
        outport_dataDeq = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (outport_dataValid !== 2'b01 || port_data(0) !== tail[i]) begin
                failures++; $display("FAIL stall_drain%0d: got valid=%b head=%h want 01/%h", i, outport_dataValid, port_data(0), tail[i]);
            end
        end
        step(1);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL stall_empty: got %b want 00", outport_dataValid); end
        step(3);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL stall_no_7th: got %b want 00", outport_dataValid); end
        control_in      = 32'h0;
        outport_dataDeq = 2'b00;
        step(2);
    endtask

    task automatic test_len_zero();
        control_in = 32'h0030_0201;        // SEED=0x30 PORT=1 LEN=0 START
        step(4);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL len0_none: got %b want 00", outport_dataValid); end
        control_in = 32'h0;
        step(1);
        control_in = 32'h0030_0203;        // LEN=1
        step(2);
        checks++; if (outport_dataValid !== 2'b10 || port_data(1) !== 32'h30) begin failures++; $display("FAIL len1_flit: got valid=%b data=%h want 10/30", outport_dataValid, port_data(1)); end
        step(3);
        outport_dataDeq = 2'b10;
        step(1);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL len1_single: got %b want 00", outport_dataValid); end
        outport_dataDeq = 2'b00;
        control_in      = 32'h0;
        step(1);
        control_in = 32'h0040_0607;        // PORT=3 is out of range
        step(5);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL bad_port_discard: got %b want 00", outport_dataValid); end
        control_in = 32'h0;
        step(2);
    endtask

    task automatic test_arbiter();
        logic [WIDTH-1:0] exp_co;
        logic [WIDTH-1:0] idle_co;
        inport_dataIn    = {32'h0000_000B, 32'h0000_000A};
        inport_dataValid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (inport_dataDeq !== 2'(1 << (i % 2))) begin failures++; $display("FAIL arb_grant%0d: got %b want %b", i, inport_dataDeq, 2'(1 << (i % 2))); end
            step(1);
            exp_co = (i % 2 == 0) ? 32'h8000_000A : 32'h8800_000B;
            checks++; if (control_out !== exp_co) begin failures++; $display("FAIL arb_status%0d: got %h want %h", i, control_out, exp_co); end
        end
        inport_dataValid = 2'b10;
        #1;
        checks++; if (inport_dataDeq !== 2'b10) begin failures++; $display("FAIL arb_skip: got %b want 10", inport_dataDeq); end
        step(1);
        checks++; if (control_out !== 32'h8800_000B) begin failures++; $display("FAIL arb_skip_status: got %h want 8800000b", control_out); end
        inport_dataValid = 2'b00;
        #1;
        checks++; if (inport_dataDeq !== 2'b00) begin failures++; $display("FAIL arb_idle_deq: got %b want 00", inport_dataDeq); end
        step(1);
`ifdef PE_NODE_RX_STICKY_EN
        idle_co = 32'h8800_000B;
`else
        idle_co = 32'h0;
`endif
        checks++; if (control_out !== idle_co) begin failures++; $display("FAIL arb_idle_status: got %h want %h", control_out, idle_co); end
    endtask

    task automatic test_sticky();
        logic [WIDTH-1:0] idle_co;
`ifdef PE_NODE_RX_STICKY_EN
        idle_co = 32'h8000_0005;
`else
        idle_co = 32'h0;
`endif
        inport_dataIn    = {32'h0, 32'h0000_0005};
        inport_dataValid = 2'b01;
        #1;
        checks++; if (inport_dataDeq !== 2'b01) begin failures++; $display("FAIL sticky_grant: got %b want 01", inport_dataDeq); end
        step(1);
        inport_dataValid = 2'b00;
        checks++; if (control_out !== 32'h8000_0005) begin failures++; $display("FAIL sticky_first: got %h want 80000005", control_out); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (control_out !== idle_co) begin failures++; $display("FAIL sticky_idle%0d: got %h want %h", i, control_out, idle_co); end
        end
    endtask

    task automatic test_reset_mid_send();
        inport_dataIn    = {32'h0, 32'h0000_0007};
        inport_dataValid = 2'b01;
        outport_dataDeq  = 2'b00;
        control_in       = 32'h0050_0011;  // SEED=0x50 PORT=0 LEN=8 START
        step(3);
        checks++; if (outport_dataValid !== 2'b01 || control_out !== 32'h8000_0007) begin failures++; $display("FAIL mid_pre: got valid=%b ctrl=%h want 01/80000007", outport_dataValid, control_out); end
        #3;
        RST = 1'b1;
        #1;
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL mid_rst_valid: got %b want 00", outport_dataValid); end
        checks++; if (control_out !== 32'h0 || inport_dataDeq !== 2'b00) begin failures++; $display("FAIL mid_rst_ctrl: got ctrl=%h deq=%b want 0/00", control_out, inport_dataDeq); end
        #2;
        inport_dataValid = 2'b00;
        RST = 1'b0;
        step(1);
        checks++; if (outport_dataValid !== 2'b00) begin failures++; $display("FAIL mid_relatch: got %b want 00", outport_dataValid); end
        step(1);
        checks++; if (outport_dataValid !== 2'b01 || port_data(0) !== 32'h50) begin failures++; $display("FAIL mid_restart: got valid=%b head=%h want 01/50", outport_dataValid, port_data(0)); end
        control_in      = 32'h0;
        outport_dataDeq = 2'b01;
        step(12);
        outport_dataDeq = 2'b00;
    endtask

    initial begin
        test_reset();
        test_send_basic();
        test_stall();
        test_len_zero();
        test_arbiter();
        test_sticky();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
